// File: rtl/reference_change_timestamper.sv
`default_nettype none
// ============================================================================
// Module   : reference_change_timestamper
// Brief    : Samples an observed value every clock edge and queues a
//            {cycle, value} token whenever it changes (plus one
//            initialization token at timestamp 0 after reset). Tokens drain
//            through a small FIFO over a ready/valid port.
// Revision : 1.0 - initial release
// ============================================================================
module reference_change_timestamper #(
  parameter int DATA_WIDTH = 8,
  parameter int TIME_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            d,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [TIME_WIDTH-1:0]            out_time,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Token storage; no reset needed because reads are gated by occupancy.
  logic [TIME_WIDTH-1:0] mem_time_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];

  logic [TIME_WIDTH-1:0] cycle_q, cycle_d;
  logic                  primed_q, primed_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic event_w;
  logic pop_w;
  logic push_w;
  logic drop_w;

  // Event detection and FIFO handshake decisions for the current edge.
  always_comb begin
    event_w = !primed_q || (d != last_q);
    pop_w   = (count_q != '0) && out_ready;
    // A same-edge pop frees a slot, so a full FIFO can still accept.
    push_w  = event_w && ((count_q < DEPTH_C) || pop_w);
    drop_w  = event_w && !push_w;
  end

  // Next-state values for counter, change tracker, pointers and flags.
  always_comb begin
    cycle_d    = cycle_q + TIME_WIDTH'(1);
    primed_d   = 1'b1;
    // last follows d even when a token is dropped, so a value lost to
    // overflow does not retrigger on the following edges.
    last_d     = event_w ? d : last_q;
    wr_ptr_d   = push_w ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop_w  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    overflow_d = overflow_q || drop_w;
    count_d    = count_q;
    case ({push_w, pop_w})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_q    <= '0;
      primed_q   <= 1'b0;
      last_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      cycle_q    <= cycle_d;
      primed_q   <= primed_d;
      last_q     <= last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Token write: timestamp is the pre-edge counter value.
  always_ff @(posedge clock) begin
    if (push_w) begin
      mem_time_q[wr_ptr_q] <= cycle_q;
      mem_data_q[wr_ptr_q] <= d;
    end
  end

  // Head of FIFO presented combinationally; reads zero when empty.
  always_comb begin
    out_valid = (count_q != '0);
    out_time  = out_valid ? mem_time_q[rd_ptr_q] : '0;
    out_data  = out_valid ? mem_data_q[rd_ptr_q] : '0;
    overflow  = overflow_q;
    count     = count_q;
  end

endmodule
`default_nettype wire

// File: doc/reference_change_timestamper.md
Name: reference_change_timestamper

Overview:
- Sits directly downstream of the reference register model. Samples the register's q output on every rising clock edge.
- Emits a timestamped token {cycle, value} whenever the sampled value differs from the previously sampled value.
- The first token after reset carries the initialization value at timestamp 0.
- Tokens are buffered in a small FIFO and drained over a ready/valid port toward the timestamped-model comparator.

Parameters:
- DATA_WIDTH, 8, width of the observed signal.
- TIME_WIDTH, 32, width of the free-running cycle counter and of the timestamp field.
- FIFO_DEPTH, 4, token buffer entries; power of two, >= 2.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; asserting (0) clears all state immediately.
- d  input  DATA_WIDTH  observed value (reference register q).
- out_valid  output  1  a token is available.
- out_ready  input  1  consumer accepts the token this cycle.
- out_time  output  TIME_WIDTH  timestamp of the head token.
- out_data  output  DATA_WIDTH  value of the head token.
- overflow  output  1  sticky: at least one token was dropped since reset.
- count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - cycle counter=0, FIFO empty, out_valid=0, overflow=0, count=0.
  - out_time and out_data read 0.
  - primed flag=0, last-value register=0.
- Cycle counter:
  - Increments by 1 every rising edge while reset=1.
  - Wraps modulo 2^TIME_WIDTH with no flag.
  - The first edge after reset release samples with timestamp 0.
- Event detection, evaluated per edge with the pre-edge counter value T:
  - If primed=0: generate an event with {T, d}, set primed=1, last=d. This is the initialization token, so T=0.
  - Else if d != last: generate an event with {T, d} and set last=d.
  - Else: no event.
- Push and pop:
  - An event is pushed if count<FIFO_DEPTH, or if a pop occurs in the same edge (out_valid & out_ready).
  - Simultaneous push and pop at full is legal and keeps count=FIFO_DEPTH.
  - If an event cannot be pushed, it is dropped, overflow is set to 1 and holds until reset, and last is still updated to d. This prevents repeat events for the same value.
- Output port:
  - out_valid = (count != 0).
  - out_time and out_data reflect the head entry combinationally from FIFO storage.
  - They are stable while out_valid=1 and out_ready=0.
  - A pop occurs on a rising edge with out_valid=1 and out_ready=1.
  - out_ready while empty has no effect.
- Latency: an event sampled at edge N appears on out_valid after edge N, when the FIFO was empty. The FIFO has no bypass.
- Ordering: tokens leave in strict generation order. Timestamps are strictly increasing except across a counter wrap.
- Pointers: read and write pointers wrap modulo FIFO_DEPTH. count is derived as a separate register, updated +1, -1 or 0.
- Reset mid-operation: all buffered tokens are discarded, primed clears, and the next edge after release emits a fresh initialization token at timestamp 0.
- X on d: it is compared as-is. X-handling beyond simulator semantics is not required.

Test Plan:
- Init token: release reset with d=0x5A and out_ready=1 → first token {0, 0x5A}. No further tokens while d is held.
- Change tracking: d=0x5A for cycles 0-2, 0x11 at cycle 3, 0x22 at cycle 7 → tokens {0,0x5A}, {3,0x11}, {7,0x22}; count peaks at 1.
- Backpressure/full:
  - Setup: out_ready=0; d changes at cycles 1, 2, 3, 4 after the init token.
  - Expected at cycle 4: count reaches 4 after the cycle-3 event, the cycle-4 event is dropped, overflow=1.
  - After raising out_ready, exactly the tokens {0,·}, {1,·}, {2,·}, {3,·} drain.
- Push+pop at full: FIFO full, out_ready=1 and d changes on the same edge → head popped, new token appended, count stays 4, overflow stays 0.
- Counter wrap: TIME_WIDTH=4; d toggles at cycles 14 and 17 → tokens with out_time 14 and 1. No error.
- Async reset mid-stream: assert reset=0 between edges with 3 tokens buffered → out_valid drops immediately, count=0, overflow=0. After release with d=0x33, the first token is {0,0x33}.
